// File: rtl/multihex_pkg.sv
// Shared definitions for the multiplexed hex display driver: segment layout,
// scan FSM states and a width helper for the counters.
package multihex_pkg;

   localparam int unsigned SEG_W   = 7;
   localparam int unsigned SEG_DP  = 7;
   localparam logic [7:0]  SEG_OFF = 8'hFF;

   typedef enum logic [1:0] {
      StBlank,
      StLoad,
      StShow
   } state_e;

   // Ceiling log2, never less than 1 bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((32'd1 << w) < n) w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-high 7-segment decode, bit order {g,f,e,d,c,b,a}.
// b and d are rendered lower case so they differ from 8 and 0.
module hex_to_7seg
   import multihex_pkg::*;
(
   input  logic [3:0]       hex_i,
   output logic [SEG_W-1:0] seg_o
);

   always_comb begin
      seg_o = '0;
      unique case (hex_i)
         4'h0: seg_o = 7'h3F;
         4'h1: seg_o = 7'h06;
         4'h2: seg_o = 7'h5B;
         4'h3: seg_o = 7'h4F;
         4'h4: seg_o = 7'h66;
         4'h5: seg_o = 7'h6D;
         4'h6: seg_o = 7'h7D;
         4'h7: seg_o = 7'h07;
         4'h8: seg_o = 7'h7F;
         4'h9: seg_o = 7'h6F;
         4'hA: seg_o = 7'h77;
         4'hB: seg_o = 7'h7C;
         4'hC: seg_o = 7'h39;
         4'hD: seg_o = 7'h5E;
         4'hE: seg_o = 7'h79;
         4'hF: seg_o = 7'h71;
      endcase
   end

endmodule

// File: rtl/multihex_display_driver.sv
// N-digit multiplexed 7-segment scanner with blanking gaps, leading-zero suppression,
// per-digit enables, PWM brightness and a per-frame input snapshot.
module multihex_display_driver
   import multihex_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned HOLD_W       = 8,
   parameter int unsigned BLANK_CYCLES = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [4*NUM_DIGITS-1:0] dataword_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic [NUM_DIGITS-1:0]   digit_en_i,
   input  logic                    lz_blank_i,
   input  logic [HOLD_W-1:0]       brightness_i,
   output logic [NUM_DIGITS-1:0]   sel_o,
   output logic [7:0]              seg_o,
   output logic                    frame_done_o
);

   localparam int unsigned DigW   = clog2(NUM_DIGITS);
   localparam int unsigned BlankW = clog2(BLANK_CYCLES + 1);

   localparam logic [HOLD_W-1:0] HoldMax   = '1;
   localparam logic [DigW-1:0]   LastDigit = DigW'(NUM_DIGITS - 1);
   localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);

   state_e                  state_q;
   logic [BlankW-1:0]       blank_cnt_q;
   logic [HOLD_W-1:0]       hold_cnt_q;
   logic [DigW-1:0]         digit_q;
   logic [4*NUM_DIGITS-1:0] word_q;
   logic [NUM_DIGITS-1:0]   dp_q;
   logic [NUM_DIGITS-1:0]   en_q;
   logic                    lz_q;
   logic [NUM_DIGITS-1:0]   sel_q;
   logic [7:0]              seg_q;
   logic                    frame_done_q;

   logic [4*NUM_DIGITS-1:0] word_d;
   logic [NUM_DIGITS-1:0]   dp_d;
   logic [NUM_DIGITS-1:0]   en_d;
   logic                    lz_d;
   logic                    first_digit;
   logic [3:0]              nibble;
   logic [SEG_W-1:0]        seg_raw;
   logic [NUM_DIGITS-1:0]   visible;
   logic [NUM_DIGITS-1:0]   sel_on;
   logic [HOLD_W-1:0]       hold_nxt;
   logic [NUM_DIGITS-1:0]   sel_first;
   logic [NUM_DIGITS-1:0]   sel_next;

   // The snapshot is refreshed only when digit 0 is about to load, so a whole
   // frame is drawn from one coherent copy of the inputs.
   assign first_digit = (digit_q == '0);
   assign word_d      = first_digit ? dataword_i : word_q;
   assign dp_d        = first_digit ? dp_i       : dp_q;
   assign en_d        = first_digit ? digit_en_i : en_q;
   assign lz_d        = first_digit ? lz_blank_i : lz_q;
   assign nibble      = word_d[4*int'(digit_q) +: 4];

   hex_to_7seg u_hex_to_7seg (
      .hex_i (nibble),
      .seg_o (seg_raw)
   );

   // A digit is lz-blanked when it and every more significant nibble are zero.
   always_comb begin
      visible = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         visible[k] = en_q[k] && !(lz_q && (k != 0) && ((word_q >> (4 * k)) == '0));
      end
   end

   assign sel_on    = ~(NUM_DIGITS'(1) << digit_q);
   assign hold_nxt  = hold_cnt_q + 1'b1;
   assign sel_first = ((brightness_i != '0) && visible[digit_q]) ? sel_on : '1;
   assign sel_next  = ((hold_nxt < brightness_i) && visible[digit_q]) ? sel_on : '1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StBlank;
         blank_cnt_q  <= '0;
         hold_cnt_q   <= '0;
         digit_q      <= '0;
         word_q       <= '0;
         dp_q         <= '0;
         en_q         <= '0;
         lz_q         <= 1'b0;
         sel_q        <= '1;
         seg_q        <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            StBlank: begin
               sel_q <= '1;
               if (blank_cnt_q == BlankLast) begin
                  blank_cnt_q <= '0;
                  state_q     <= StLoad;
                  word_q      <= word_d;
                  dp_q        <= dp_d;
                  en_q        <= en_d;
                  lz_q        <= lz_d;
                  // seg moves while every select is still off
                  seg_q       <= ~{dp_d[digit_q], seg_raw};
               end else begin
                  blank_cnt_q <= blank_cnt_q + 1'b1;
               end
            end
            StLoad: begin
               state_q    <= StShow;
               hold_cnt_q <= '0;
               sel_q      <= sel_first;
            end
            StShow: begin
               if (hold_cnt_q == HoldMax) begin
                  state_q <= StBlank;
                  sel_q   <= '1;
                  digit_q <= (digit_q == LastDigit) ? '0 : digit_q + 1'b1;
               end else begin
                  hold_cnt_q <= hold_nxt;
                  sel_q      <= sel_next;
                  if ((hold_nxt == HoldMax) && (digit_q == LastDigit)) frame_done_q <= 1'b1;
               end
            end
            default: state_q <= StBlank;
         endcase
      end
   end

   assign sel_o        = sel_q;
   assign seg_o        = seg_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_multihex_display_driver.sv
// Directed plus randomized bench for multihex_display_driver; every cycle is compared
// against a frame-position model derived from the scan timing rules.
module tb_multihex_display_driver;

   localparam int unsigned ND = 4;
   localparam int unsigned HW = 4;
   localparam int unsigned NB = 2;
   localparam int DP = NB + 1 + (1 << HW);
   localparam int FR = ND * DP;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] dataword = '0;
   logic [3:0]  dp = '0;
   logic [3:0]  en = '0;
   logic        lz = 1'b0;
   logic [3:0]  bright = '0;
   logic [3:0]  sel;
   logic [7:0]  seg;
   logic        fd;

   always #5 clk = ~clk;

   multihex_display_driver #(
      .NUM_DIGITS   (ND),
      .HOLD_W       (HW),
      .BLANK_CYCLES (NB)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .dataword_i   (dataword),
      .dp_i         (dp),
      .digit_en_i   (en),
      .lz_blank_i   (lz),
      .brightness_i (bright),
      .sel_o        (sel),
      .seg_o        (seg),
      .frame_done_o (fd)
   );

   int n_chk = 0;
   int n_fail = 0;
   int c = 0;

   logic [6:0]  tbl [16];
   logic [15:0] w_s;
   logic [3:0]  dp_s, en_s;
   logic        lz_s;
   logic [7:0]  seg_exp, seg_prev;
   logic [3:0]  sel_prev;
   logic        fd_prev;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
      end
   endtask

   function automatic logic vis(input int k);
      return en_s[k] && !(lz_s && (k > 0) && ((w_s >> (4 * k)) == 16'h0));
   endfunction

   task automatic reset_model();
      c = 0;
      w_s = '0; dp_s = '0; en_s = '0; lz_s = 1'b0;
      seg_exp = 8'hFF; seg_prev = 8'hFF; sel_prev = 4'hF; fd_prev = 1'b0;
   endtask

   // c counts rising edges since reset release; position in frame fixes everything.
   task automatic check();
      int ph, d;
      logic [3:0] sel_exp;
      ph = c % DP;
      d  = (c / DP) % ND;
      if (ph == NB && d == 0) begin
         w_s = dataword; dp_s = dp; en_s = en; lz_s = lz;
      end
      if (ph == NB) seg_exp = ~{dp_s[d], tbl[w_s[4*d +: 4]]};
      sel_exp = 4'hF;
      if (ph > NB && (ph - NB - 1) < int'(bright) && vis(d)) sel_exp[d] = 1'b0;
      chk("sel", 8'(sel), 8'(sel_exp));
      chk("seg", seg, seg_exp);
      chk("frame_done", 8'(fd), 8'((d == ND - 1) && (ph == DP - 1)));
      chk("sel_onehot", 8'($countones(~sel) <= 1), 8'd1);
      chk("seg_stable", 8'((seg === seg_prev) || (sel_prev == 4'hF && sel == 4'hF)), 8'd1);
      chk("fd_width", 8'(!(fd && fd_prev)), 8'd1);
      seg_prev = seg; sel_prev = sel; fd_prev = fd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      c++;
      check();
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < FR; i++) begin
         if (c % FR == target) break;
         step();
      end
   endtask

   initial begin
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      reset_model();
      #2 rst_n = 1'b0;
      #21;
      chk("rst_sel", 8'(sel), 8'h0F);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_fd", 8'(fd), 8'h00);

      // Full-brightness scan of 12AF with dp on digit 2
      dataword = 16'h12AF; dp = 4'b0100; en = 4'hF; lz = 1'b0; bright = 4'd15;
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      check();
      repeat (2 * FR) step();

      // Reset in the middle of digit 2 SHOW
      run_to(2 * DP + NB + 5);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_sel", 8'(sel), 8'h0F);
      chk("midrst_seg", seg, 8'hFF);
      chk("midrst_fd", 8'(fd), 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
      check();
      repeat (FR + 5) step();

      // Leading-zero suppression
      dataword = 16'h0030; lz = 1'b1; dp = 4'b1111;
      run_to(0); repeat (FR) step();
      dataword = 16'h0000;
      run_to(0); repeat (FR) step();
      lz = 1'b0;
      run_to(0); repeat (FR) step();

      // Frame coherence: change mid-frame during digit 2
      dataword = 16'h1111; dp = 4'b0000;
      run_to(0); repeat (FR) step();
      run_to(2 * DP + NB + 4);
      dataword = 16'h2222;
      repeat (2 * FR) step();

      // Brightness and enables
      bright = 4'd0;
      run_to(0); repeat (FR) step();
      bright = 4'd5;
      run_to(0); repeat (FR) step();
      en = 4'b1011;
      run_to(0); repeat (FR) step();

      // Randomized inputs changed at random points in the frame
      for (int f = 0; f < 20; f++) begin
         dataword = 16'($urandom);
         case ($urandom_range(0, 3))
            0: dataword = dataword & 16'h00FF;
            1: dataword = dataword & 16'h000F;
            2: dataword = 16'h0;
            default: ;
         endcase
         dp = 4'($urandom); en = 4'($urandom); lz = 1'($urandom);
         bright = 4'($urandom);
         repeat ($urandom_range(10, FR)) step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
